// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer: one-shot or auto-reload, one-cycle registered done pulse at expiry.
// Load-to-first-decrement latency is one cycle; expiry lands N enabled cycles after loading N; enable=0 holds.
module down_counter_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             auto_reload,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             zero
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q, done_d;
    logic             busy_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
            busy_q   <= (state_d == RUN);
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;

        if (abort) begin
            state_d = IDLE;
            count_d = '0;
        end else if (load) begin
            // A zero load is a cancel that also clears the reload register.
            count_d  = load_value;
            reload_d = load_value;
            state_d  = (load_value != '0) ? RUN : IDLE;
        end else begin
            case (state_q)
                RUN: begin
                    if (enable) begin
                        if (count_q == ONE) begin
                            done_d = 1'b1;
                            if (auto_reload) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = EXPIRED;
                            end
                        end else begin
                            count_d = count_q - ONE;
                        end
                    end
                end
                EXPIRED: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign zero  = (count_q == '0);

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed plus randomized bench for down_counter_timer against a cycle-level reference model.
module tb_down_counter_timer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] load_value = '0;
    logic         enable = 1'b0;
    logic         auto_reload = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] count;
    logic         busy;
    logic         done;
    logic         zero;

    down_counter_timer #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .load(load), .load_value(load_value),
        .enable(enable), .auto_reload(auto_reload), .abort(abort),
        .count(count), .busy(busy), .done(done), .zero(zero)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference: remaining count, the value to reload, whether a run is active, and the pulse.
    int m_cnt = 0;
    int m_rel = 0;
    bit m_run = 1'b0;
    bit m_done = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit rst, input bit ld, input int lv, input bit en,
                       input bit ar, input bit ab);
        @(negedge clk);
        reset       = rst;
        load        = ld;
        load_value  = lv[W-1:0];
        enable      = en;
        auto_reload = ar;
        abort       = ab;
        @(posedge clk);
        m_done = 1'b0;
        if (rst) begin
            m_cnt = 0; m_rel = 0; m_run = 1'b0;
        end else if (ab) begin
            m_cnt = 0; m_run = 1'b0;
        end else if (ld) begin
            m_cnt = lv; m_rel = lv; m_run = (lv != 0);
        end else if (m_run && en) begin
            if (m_cnt == 1) begin
                m_done = 1'b1;
                if (ar) m_cnt = m_rel;
                else begin
                    m_cnt = 0; m_run = 1'b0;
                end
            end else begin
                m_cnt = m_cnt - 1;
            end
        end
        #1;
        chk("count", 32'(count), 32'(m_cnt));
        chk("busy",  32'(busy),  32'(m_run));
        chk("done",  32'(done),  32'(m_done));
        chk("zero",  32'(zero),  32'(m_cnt == 0));
    endtask

    initial begin
        int n;

        // Reset held two cycles, then stable idle.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0);
        chk("t1_zero", 32'(zero), 32'd1);

        // One-shot from 5 with continuous enable.
        cyc(0, 1, 5, 1, 0, 0);
        chk("t2_load", 32'(count), 32'd5);
        for (int i = 1; i <= 5; i++) begin
            cyc(0, 0, 0, 1, 0, 0);
            chk("t2_seq", 32'(count), 32'(5 - i));
            chk("t2_done", 32'(done), 32'(i == 5));
        end
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("t2_idle", 32'(count), 32'd0);

        // Enable gating: 1,0,0,1,1.
        cyc(0, 1, 3, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("t3_end", 32'(count), 32'd0);
        chk("t3_done", 32'(done), 32'd1);
        cyc(0, 0, 0, 0, 0, 0);

        // Auto-reload period 3.
        cyc(0, 1, 3, 1, 1, 0);
        for (int i = 1; i < 9; i++) begin
            cyc(0, 0, 0, 1, 1, 0);
            chk("t4_seq", 32'(count), 32'(3 - (i % 3)));
            chk("t4_done", 32'(done), 32'(i % 3 == 0));
        end
        cyc(0, 0, 0, 0, 0, 1);

        // Load on the terminal cycle wins, then abort, then abort+load.
        cyc(0, 1, 4, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0);
        chk("t5_at1", 32'(count), 32'd1);
        cyc(0, 1, 6, 1, 0, 0);
        chk("t5_reload", 32'(count), 32'd6);
        chk("t5_nodone", 32'(done), 32'd0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0);
        chk("t5_at3", 32'(count), 32'd3);
        cyc(0, 0, 0, 1, 0, 1);
        chk("t5_abort", 32'(busy), 32'd0);
        cyc(0, 1, 5, 1, 0, 0);
        cyc(0, 1, 9, 1, 0, 1);
        chk("t5_ab_ld", 32'(count), 32'd0);

        // Mid-run reset.
        cyc(0, 1, 7, 1, 1, 0);
        cyc(0, 0, 0, 1, 1, 0);
        cyc(1, 0, 0, 1, 1, 0);

        // Zero load, then full-scale one-shot latency.
        cyc(0, 1, 0, 1, 0, 0);
        chk("t6_zero_busy", 32'(busy), 32'd0);
        cyc(0, 1, 15, 1, 0, 0);
        n = 0;
        do begin
            cyc(0, 0, 0, 1, 0, 0);
            n++;
        end while (!done && n < 20);
        chk("t6_latency", 32'(n), 32'd15);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, 0);
        chk("t6_nowrap", 32'(count), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(63) == 0), ($urandom_range(7) == 0), int'($urandom_range(15)),
                ($urandom_range(3) != 0), 1'($urandom), ($urandom_range(31) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
